// File: rtl/interrupt_priority_resolver.sv
// interrupt_priority_resolver
// Request/priority engine for the 8259-style PIC. It captures IR0..IR7
// into the IRR and resolves priority against the mask and the in-service
// register. It raises INTERNAL_INT to the control unit and runs the
// two-pulse INTA_ acknowledge against the ISR. It also handles AEOI,
// non-specific EOI, specific EOI and priority rotation.
module interrupt_priority_resolver #(
  parameter int IR_SYNC = 1
) (
  input  logic       CLK,
  input  logic       RST_,
  input  logic [7:0] IR,
  input  logic       LEVEL,
  input  logic [7:0] MASK,
  input  logic       AEOI,
  input  logic       ROTATE,
  input  logic       INTA_,
  input  logic       EOI_WR,
  input  logic       SEOI_WR,
  input  logic [2:0] SEOI_LVL,
  input  logic       RD_IRR,
  input  logic       RD_ISR,
  output logic       INTERNAL_INT,
  output logic [2:0] IR_NUM,
  output logic [7:0] IRR,
  output logic [7:0] ISR,
  output logic [7:0] REG_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2
  } state_t;

  // Rank of a level under the current pointer: 0 = highest priority.
  // The level right after lowp is the highest, so the subtraction wraps mod 8.
  function automatic logic [2:0] prio_rank(input logic [2:0] lvl,
                                           input logic [2:0] lowp);
    prio_rank = lvl - lowp - 3'd1;
  endfunction

  // Highest-priority set bit of vec, returned as {valid, level}.
  // The scan runs from the lowest to the highest priority, so the last hit wins.
  function automatic logic [3:0] find_highest(input logic [7:0] vec,
                                              input logic [2:0] lowp);
    logic [2:0] lvl;
    find_highest = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      lvl = lowp + 3'd1 + 3'(i);
      if (vec[lvl]) find_highest = {1'b1, lvl};
    end
  endfunction

  // ---------------------------------------------------------------- sampling
  logic [7:0] irs;
  logic [7:0] ir_prev_q;
  logic       inta_s1_q;
  logic       inta_s2_q;
  logic       inta_prev_q;
  logic       inta_fall;

  generate
    if (IR_SYNC != 0) begin : g_ir_sync
      logic [7:0] ir_s1_q;
      logic [7:0] ir_s2_q;

      // Two-flop synchronizer for the raw request lines
      always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
          ir_s1_q <= 8'h00;
          ir_s2_q <= 8'h00;
        end else begin
          ir_s1_q <= IR;
          ir_s2_q <= ir_s1_q;
        end
      end

      assign irs = ir_s2_q;
    end else begin : g_ir_direct
      assign irs = IR;
    end
  endgenerate

  // INTA_ synchronizer and previous-value flops; idle level of INTA_ is high
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      inta_s1_q   <= 1'b1;
      inta_s2_q   <= 1'b1;
      inta_prev_q <= 1'b1;
      ir_prev_q   <= 8'h00;
    end else begin
      inta_s1_q   <= INTA_;
      inta_s2_q   <= inta_s1_q;
      inta_prev_q <= inta_s2_q;
      ir_prev_q   <= irs;
    end
  end

  assign inta_fall = inta_prev_q & ~inta_s2_q;

  // ---------------------------------------------------------- resolve/state
  state_t     state_q, state_d;
  logic       int_q, int_d;
  logic [2:0] ir_num_q, ir_num_d;
  logic       spur_q, spur_d;
  logic [2:0] lowp_q, lowp_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] reg_out_q, reg_out_d;

  logic [3:0] cand;
  logic [3:0] hisr;
  logic       cand_vld;
  logic [2:0] cand_lvl;
  logic       hisr_vld;
  logic [2:0] hisr_lvl;
  logic       pending;

  // Candidate request, highest in-service level and the nesting decision
  always_comb begin
    cand     = find_highest(irr_q & ~MASK, lowp_q);
    hisr     = find_highest(isr_q, lowp_q);
    cand_vld = cand[3];
    cand_lvl = cand[2:0];
    hisr_vld = hisr[3];
    hisr_lvl = hisr[2:0];
    pending  = cand_vld &&
               (!hisr_vld || (prio_rank(cand_lvl, lowp_q) < prio_rank(hisr_lvl, lowp_q)));
  end

  // Next-state logic: IRR capture, EOI handling, acknowledge FSM, read-back
  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    ir_num_d = ir_num_q;
    spur_d   = spur_q;
    lowp_d   = lowp_q;
    isr_d    = isr_q;
    irr_d    = irr_q;

    // An edge request is held until the first acknowledge takes it; in level
    // mode the IRR simply mirrors the sampled lines.
    if (LEVEL) begin
      irr_d = irs;
    end else begin
      if ((state_q == ST_REQ) && inta_fall && cand_vld) irr_d[cand_lvl] = 1'b0;
      irr_d = irr_d | (irs & ~ir_prev_q);
    end

    // EOI clears are applied before any ISR set from the acknowledge below,
    // so an EOI and an ACK on the same bit leave that bit set.
    if (SEOI_WR) begin
      isr_d[SEOI_LVL] = 1'b0;
      if (ROTATE) lowp_d = SEOI_LVL;
    end else if (EOI_WR && hisr_vld) begin
      isr_d[hisr_lvl] = 1'b0;
      if (ROTATE) lowp_d = hisr_lvl;
    end

    case (state_q)
      ST_IDLE: begin
        int_d = pending;
        if (pending) state_d = ST_REQ;
      end
      ST_REQ: begin
        // The acknowledge is honoured even if the request vanished in the
        // same cycle; that case yields the spurious vector 7.
        if (inta_fall) begin
          state_d = ST_ACK1;
          int_d   = 1'b0;
          if (cand_vld) begin
            ir_num_d        = cand_lvl;
            isr_d[cand_lvl] = 1'b1;
            spur_d          = 1'b0;
          end else begin
            ir_num_d = 3'd7;
            spur_d   = 1'b1;
          end
        end else if (!pending) begin
          state_d = ST_IDLE;
          int_d   = 1'b0;
        end else begin
          int_d = 1'b1;
        end
      end
      ST_ACK1: begin
        int_d = 1'b0;
        if (inta_fall) begin
          state_d = ST_IDLE;
          if (AEOI && !spur_q) begin
            isr_d[ir_num_q] = 1'b0;
            if (ROTATE) lowp_d = ir_num_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
      end
    endcase

    if (RD_ISR)      reg_out_d = isr_q;
    else if (RD_IRR) reg_out_d = irr_q;
    else             reg_out_d = 8'h00;
  end

  // State registers; reset puts IR0 at the highest priority
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q   <= ST_IDLE;
      int_q     <= 1'b0;
      ir_num_q  <= 3'd0;
      spur_q    <= 1'b0;
      lowp_q    <= 3'd7;
      irr_q     <= 8'h00;
      isr_q     <= 8'h00;
      reg_out_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      int_q     <= int_d;
      ir_num_q  <= ir_num_d;
      spur_q    <= spur_d;
      lowp_q    <= lowp_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      reg_out_q <= reg_out_d;
    end
  end

  assign INTERNAL_INT = int_q;
  assign IR_NUM       = ir_num_q;
  assign IRR          = irr_q;
  assign ISR          = isr_q;
  assign REG_OUT      = reg_out_q;

endmodule

// File: tb/tb_interrupt_priority_resolver.sv
// Testbench for interrupt_priority_resolver (IR_SYNC=1).
// It applies table-driven priority/mask vectors and then hand-written
// sequences for latency, nesting, AEOI rotation, spurious acknowledge,
// read-back, specific EOI and reset during an acknowledge.
module tb_interrupt_priority_resolver;

  logic       CLK = 1'b0;
  logic       RST_;
  logic [7:0] IR;
  logic       LEVEL;
  logic [7:0] MASK;
  logic       AEOI;
  logic       ROTATE;
  logic       INTA_;
  logic       EOI_WR;
  logic       SEOI_WR;
  logic [2:0] SEOI_LVL;
  logic       RD_IRR;
  logic       RD_ISR;
  logic       INTERNAL_INT;
  logic [2:0] IR_NUM;
  logic [7:0] IRR;
  logic [7:0] ISR;
  logic [7:0] REG_OUT;

  interrupt_priority_resolver #(.IR_SYNC(1)) dut (
    .CLK(CLK), .RST_(RST_), .IR(IR), .LEVEL(LEVEL), .MASK(MASK),
    .AEOI(AEOI), .ROTATE(ROTATE), .INTA_(INTA_), .EOI_WR(EOI_WR),
    .SEOI_WR(SEOI_WR), .SEOI_LVL(SEOI_LVL), .RD_IRR(RD_IRR), .RD_ISR(RD_ISR),
    .INTERNAL_INT(INTERNAL_INT), .IR_NUM(IR_NUM), .IRR(IRR), .ISR(ISR),
    .REG_OUT(REG_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    logic [7:0] ir;
    logic [7:0] mask;
    logic       exp_int;
    logic [2:0] exp_num;
    logic [7:0] exp_isr;
    logic [7:0] exp_irr;
  } vec_t;

  sb_t  sb_q[$];
  vec_t tbl[6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_val(input string name, input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_val(input logic [7:0] act);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %h with no expected value queued", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic do_reset();
    RST_ = 1'b0; IR = 8'h00; LEVEL = 1'b0; MASK = 8'h00; AEOI = 1'b0;
    ROTATE = 1'b0; INTA_ = 1'b1; EOI_WR = 1'b0; SEOI_WR = 1'b0;
    SEOI_LVL = 3'd0; RD_IRR = 1'b0; RD_ISR = 1'b0;
    tick(2);
    RST_ = 1'b1;
    tick(1);
  endtask

  // One INTA_ low pulse: the synchronized falling edge acts on the third edge.
  task automatic inta_pulse();
    INTA_ = 1'b0;
    tick(2);
    INTA_ = 1'b1;
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //          ir     mask   int   num   isr    irr-after
    tbl[0] = '{8'h08, 8'h00, 1'b1, 3'd3, 8'h08, 8'h00};
    tbl[1] = '{8'h81, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h81};
    tbl[2] = '{8'h81, 8'h7F, 1'b1, 3'd7, 8'h80, 8'h01};
    tbl[3] = '{8'h81, 8'h00, 1'b1, 3'd0, 8'h01, 8'h80};
    tbl[4] = '{8'hF0, 8'h10, 1'b1, 3'd5, 8'h20, 8'hD0};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00};

    // Reset values while RST_ is held low
    RST_ = 1'b0; IR = 8'h00; LEVEL = 1'b0; MASK = 8'h00; AEOI = 1'b0;
    ROTATE = 1'b0; INTA_ = 1'b1; EOI_WR = 1'b0; SEOI_WR = 1'b0;
    SEOI_LVL = 3'd0; RD_IRR = 1'b0; RD_ISR = 1'b0;
    #3;
    expect_val("rst_int", 8'h00);  check_val({7'd0, INTERNAL_INT});
    expect_val("rst_irnum", 8'h00); check_val({5'd0, IR_NUM});
    expect_val("rst_irr", 8'h00);  check_val(IRR);
    expect_val("rst_isr", 8'h00);  check_val(ISR);
    expect_val("rst_regout", 8'h00); check_val(REG_OUT);

    // Table: priority and mask resolution from reset (LOWP=7), edge mode
    for (int v = 0; v < 6; v++) begin
      do_reset();
      MASK = tbl[v].mask;
      IR   = tbl[v].ir;
      expect_val($sformatf("tbl%0d_int", v), {7'd0, tbl[v].exp_int});
      expect_val($sformatf("tbl%0d_irnum", v), {5'd0, tbl[v].exp_num});
      expect_val($sformatf("tbl%0d_isr", v), tbl[v].exp_isr);
      expect_val($sformatf("tbl%0d_irr", v), tbl[v].exp_irr);
      tick(5);
      check_val({7'd0, INTERNAL_INT});
      IR = 8'h00;
      inta_pulse();
      inta_pulse();
      check_val({5'd0, IR_NUM});
      check_val(ISR);
      check_val(IRR);
    end

    // Latency with synchronizer, acknowledge and non-specific EOI
    do_reset();
    IR = 8'h08;
    expect_val("lat_irr_e2", 8'h00);
    expect_val("lat_irr_e3", 8'h08);
    expect_val("lat_int_e3", 8'h00);
    expect_val("lat_int_e4", 8'h01);
    tick(2); check_val(IRR);
    tick(1); check_val(IRR); check_val({7'd0, INTERNAL_INT});
    tick(1); check_val({7'd0, INTERNAL_INT});
    IR = 8'h00;
    expect_val("lat_irnum", 8'h03);
    expect_val("lat_isr", 8'h08);
    expect_val("lat_irr_ack", 8'h00);
    expect_val("lat_int_ack", 8'h00);
    inta_pulse();
    check_val({5'd0, IR_NUM}); check_val(ISR); check_val(IRR);
    check_val({7'd0, INTERNAL_INT});
    inta_pulse();
    EOI_WR = 1'b1;
    expect_val("eoi_isr", 8'h00);
    tick(1);
    EOI_WR = 1'b0;
    check_val(ISR);

    // Fully nested: lower level blocked, higher level preempts
    do_reset();
    IR = 8'h20; tick(5); IR = 8'h00;
    inta_pulse(); inta_pulse();
    expect_val("nest_isr5", 8'h20); check_val(ISR);
    IR = 8'h40;
    expect_val("nest_int_ir6", 8'h00);
    tick(5); check_val({7'd0, INTERNAL_INT});
    IR = 8'h44;
    expect_val("nest_int_ir2", 8'h01);
    tick(5); check_val({7'd0, INTERNAL_INT});
    expect_val("nest_irnum", 8'h02);
    expect_val("nest_isr", 8'h24);
    expect_val("nest_irr", 8'h40);
    inta_pulse(); inta_pulse();
    check_val({5'd0, IR_NUM}); check_val(ISR); check_val(IRR);

    // AEOI with rotation, level mode, IR0 and IR1 both held
    do_reset();
    LEVEL = 1'b1; AEOI = 1'b1; ROTATE = 1'b1;
    IR = 8'h03;
    expect_val("aeoi_int", 8'h01);
    tick(4); check_val({7'd0, INTERNAL_INT});
    expect_val("aeoi_irnum1", 8'h00);
    expect_val("aeoi_isr1", 8'h01);
    inta_pulse();
    check_val({5'd0, IR_NUM}); check_val(ISR);
    expect_val("aeoi_isr_clr", 8'h00);
    expect_val("aeoi_int_again", 8'h01);
    inta_pulse();
    check_val(ISR); check_val({7'd0, INTERNAL_INT});
    expect_val("aeoi_irnum2", 8'h01);
    expect_val("aeoi_isr2", 8'h02);
    inta_pulse();
    check_val({5'd0, IR_NUM}); check_val(ISR);
    inta_pulse();
    IR = 8'h00;

    // Spurious: level request withdrawn just before the first acknowledge
    do_reset();
    LEVEL = 1'b1;
    IR = 8'h10;
    expect_val("spur_int", 8'h01);
    tick(4); check_val({7'd0, INTERNAL_INT});
    IR = 8'h00;
    tick(1);
    INTA_ = 1'b0;
    expect_val("spur_irnum", 8'h07);
    expect_val("spur_isr", 8'h00);
    expect_val("spur_int_ack", 8'h00);
    tick(3);
    check_val({5'd0, IR_NUM}); check_val(ISR); check_val({7'd0, INTERNAL_INT});
    INTA_ = 1'b1;
    tick(1);
    inta_pulse();
    expect_val("spur_isr_end", 8'h00);
    check_val(ISR);

    // Mask and read-back
    do_reset();
    MASK = 8'hFF;
    IR = 8'h81;
    expect_val("mask_irr", 8'h81);
    expect_val("mask_int", 8'h00);
    tick(5); check_val(IRR); check_val({7'd0, INTERNAL_INT});
    IR = 8'h00;
    RD_IRR = 1'b1;
    expect_val("rd_irr", 8'h81);
    tick(1); check_val(REG_OUT);
    RD_IRR = 1'b0;
    expect_val("rd_none", 8'h00);
    tick(1); check_val(REG_OUT);
    MASK = 8'h00;
    expect_val("unmask_int", 8'h01);
    tick(1); check_val({7'd0, INTERNAL_INT});
    inta_pulse(); inta_pulse();
    RD_IRR = 1'b1; RD_ISR = 1'b1;
    expect_val("rd_both_isr", 8'h01);
    tick(1); check_val(REG_OUT);
    RD_IRR = 1'b0; RD_ISR = 1'b0;

    // Specific EOI with rotation (EOI_WR in the same cycle is ignored),
    // then reset in the middle of an acknowledge
    do_reset();
    IR = 8'h08; tick(4); IR = 8'h00;
    inta_pulse(); inta_pulse();
    IR = 8'h04; tick(5); IR = 8'h00;
    expect_val("seoi_pre_isr", 8'h0C);
    inta_pulse(); inta_pulse();
    check_val(ISR);
    ROTATE = 1'b1; SEOI_LVL = 3'd3; SEOI_WR = 1'b1; EOI_WR = 1'b1;
    expect_val("seoi_isr", 8'h04);
    tick(1);
    SEOI_WR = 1'b0; EOI_WR = 1'b0;
    check_val(ISR);
    IR = 8'h11;
    expect_val("rot_int", 8'h01);
    expect_val("rot_irnum", 8'h04);
    expect_val("rot_isr", 8'h14);
    tick(5); check_val({7'd0, INTERNAL_INT});
    inta_pulse();
    check_val({5'd0, IR_NUM}); check_val(ISR);
    RST_ = 1'b0;
    #2;
    expect_val("midrst_isr", 8'h00);
    expect_val("midrst_irr", 8'h00);
    expect_val("midrst_int", 8'h00);
    expect_val("midrst_irnum", 8'h00);
    check_val(ISR); check_val(IRR); check_val({7'd0, INTERNAL_INT});
    check_val({5'd0, IR_NUM});
    IR = 8'h00; ROTATE = 1'b0;
    tick(1);
    RST_ = 1'b1;
    expect_val("postrst_int", 8'h00);
    tick(6); check_val({7'd0, INTERNAL_INT});
    IR = 8'h11;
    expect_val("postrst_lowp_irnum", 8'h00);
    tick(5);
    inta_pulse();
    check_val({5'd0, IR_NUM});
    inta_pulse();
    IR = 8'h00;

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
